// File: rtl/read_stage_rr_arbiter_n.sv
// N-input round-robin arbiter for vector register-file read requests.
// Picks one valid requester per cycle with rotating priority and forwards its
// vs / groupIndex / readSource / instructionIndex plus the winner's index.
// REG_OUT=1 puts a register slice on the output (1-cycle latency).
// REG_OUT=0 drives the output combinationally (0-cycle latency).
//
// Handshake: a transfer happens on a rising clock edge when valid and ready
// are both high on the same interface. io_in_ready is one-hot (the grant) or
// zero. It depends on the valid inputs only through the grant decision.
// An offered output stays stable until it is accepted by io_out_ready.
module read_stage_rr_arbiter_n #(
  parameter int N       = 4,
  parameter int VS_W    = 5,
  parameter int GROUP_W = 4,
  parameter int SRC_W   = 4,
  parameter int INST_W  = 3,
  parameter int REG_OUT = 1,
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         io_in_valid,
  output logic [N-1:0]         io_in_ready,
  input  logic [N*VS_W-1:0]    io_in_bits_vs,
  input  logic [N*GROUP_W-1:0] io_in_bits_groupIndex,
  input  logic [N*SRC_W-1:0]   io_in_bits_readSource,
  input  logic [N*INST_W-1:0]  io_in_bits_instructionIndex,
  input  logic                 io_out_ready,
  output logic                 io_out_valid,
  output logic [VS_W-1:0]      io_out_bits_vs,
  output logic [GROUP_W-1:0]   io_out_bits_groupIndex,
  output logic [SRC_W-1:0]     io_out_bits_readSource,
  output logic [INST_W-1:0]    io_out_bits_instructionIndex,
  output logic [IDX_W-1:0]     io_out_bits_grant
);

  // Index of the most recently served requester; priority starts just above it.
  logic [IDX_W-1:0] last_q, last_d;

  logic             any_valid;
  logic             found;
  logic [IDX_W-1:0] grant_idx;
  logic [N-1:0]     grant_oh;
  logic             can_accept;
  logic             load;

  logic [VS_W-1:0]    mux_vs;
  logic [GROUP_W-1:0] mux_group;
  logic [SRC_W-1:0]   mux_src;
  logic [INST_W-1:0]  mux_inst;

  assign any_valid = |io_in_valid;

  // Rotating-priority scan: the first valid requester from last_q+1 upward, wrapping.
  always_comb begin
    int j;
    j         = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_q) + k) % N;
      if (!found && io_in_valid[j]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  // One-hot form of the grant, zero when nothing is valid.
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N; i++) begin
      grant_oh[i] = found && (grant_idx == IDX_W'(i));
    end
  end

  // AND-OR select of the winner's fields; all zero when there is no grant.
  always_comb begin
    mux_vs    = '0;
    mux_group = '0;
    mux_src   = '0;
    mux_inst  = '0;
    for (int i = 0; i < N; i++) begin
      mux_vs    = mux_vs    | (io_in_bits_vs[i*VS_W +: VS_W]                 & {VS_W{grant_oh[i]}});
      mux_group = mux_group | (io_in_bits_groupIndex[i*GROUP_W +: GROUP_W]   & {GROUP_W{grant_oh[i]}});
      mux_src   = mux_src   | (io_in_bits_readSource[i*SRC_W +: SRC_W]       & {SRC_W{grant_oh[i]}});
      mux_inst  = mux_inst  | (io_in_bits_instructionIndex[i*INST_W +: INST_W] & {INST_W{grant_oh[i]}});
    end
  end

  assign load        = any_valid & can_accept;
  // Ready is forced low while reset is asserted, even though the flops are already cleared.
  assign io_in_ready = grant_oh & {N{can_accept & ~reset}};

  // Priority only rotates when a request is actually transferred.
  always_comb begin
    last_d = last_q;
    if (load) begin
      last_d = grant_idx;
    end
  end

  // Pointer register; reset value N-1 gives requester 0 first pick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= IDX_W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic               out_valid_q, out_valid_d;
      logic [VS_W-1:0]    out_vs_q, out_vs_d;
      logic [GROUP_W-1:0] out_group_q, out_group_d;
      logic [SRC_W-1:0]   out_src_q, out_src_d;
      logic [INST_W-1:0]  out_inst_q, out_inst_d;
      logic [IDX_W-1:0]   out_grant_q, out_grant_d;

      // The slot can take a new entry when empty or when it is draining this cycle.
      assign can_accept = ~out_valid_q | io_out_ready;

      // Load replaces the entry in place; otherwise a drain clears valid and bits hold.
      always_comb begin
        out_valid_d = out_valid_q;
        out_vs_d    = out_vs_q;
        out_group_d = out_group_q;
        out_src_d   = out_src_q;
        out_inst_d  = out_inst_q;
        out_grant_d = out_grant_q;
        if (load) begin
          out_valid_d = 1'b1;
          out_vs_d    = mux_vs;
          out_group_d = mux_group;
          out_src_d   = mux_src;
          out_inst_d  = mux_inst;
          out_grant_d = grant_idx;
        end else if (io_out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      // Output slice registers; reset discards any held entry.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          out_valid_q <= 1'b0;
          out_vs_q    <= '0;
          out_group_q <= '0;
          out_src_q   <= '0;
          out_inst_q  <= '0;
          out_grant_q <= '0;
        end else begin
          out_valid_q <= out_valid_d;
          out_vs_q    <= out_vs_d;
          out_group_q <= out_group_d;
          out_src_q   <= out_src_d;
          out_inst_q  <= out_inst_d;
          out_grant_q <= out_grant_d;
        end
      end

      assign io_out_valid                 = out_valid_q;
      assign io_out_bits_vs               = out_vs_q;
      assign io_out_bits_groupIndex       = out_group_q;
      assign io_out_bits_readSource       = out_src_q;
      assign io_out_bits_instructionIndex = out_inst_q;
      assign io_out_bits_grant            = out_grant_q;
    end else begin : g_comb_out
      // Without the slice, acceptance is exactly the downstream ready.
      assign can_accept                   = io_out_ready;
      assign io_out_valid                 = any_valid;
      assign io_out_bits_vs               = mux_vs;
      assign io_out_bits_groupIndex       = mux_group;
      assign io_out_bits_readSource       = mux_src;
      assign io_out_bits_instructionIndex = mux_inst;
      assign io_out_bits_grant            = grant_idx;
    end
  endgenerate

endmodule

// File: tb/tb_read_stage_rr_arbiter_n.sv
// Bench for read_stage_rr_arbiter_n: a registered N=4 instance and a
// combinational N=2 instance, driven from tables plus a few hand sequences.
module tb_read_stage_rr_arbiter_n;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- N=4, REG_OUT=1 instance ----------------
  logic [3:0]  a_valid, a_ready;
  logic [19:0] a_vs;
  logic [15:0] a_group, a_src;
  logic [11:0] a_inst;
  logic        a_oready, a_ovalid;
  logic [4:0]  a_ovs;
  logic [3:0]  a_ogroup, a_osrc;
  logic [2:0]  a_oinst;
  logic [1:0]  a_ogrant;

  read_stage_rr_arbiter_n #(.N(4), .REG_OUT(1)) u4 (
    .clock(clock), .reset(reset),
    .io_in_valid(a_valid), .io_in_ready(a_ready),
    .io_in_bits_vs(a_vs), .io_in_bits_groupIndex(a_group),
    .io_in_bits_readSource(a_src), .io_in_bits_instructionIndex(a_inst),
    .io_out_ready(a_oready), .io_out_valid(a_ovalid),
    .io_out_bits_vs(a_ovs), .io_out_bits_groupIndex(a_ogroup),
    .io_out_bits_readSource(a_osrc), .io_out_bits_instructionIndex(a_oinst),
    .io_out_bits_grant(a_ogrant)
  );

  // ---------------- N=2, REG_OUT=0 instance ----------------
  logic [1:0] b_valid, b_ready;
  logic [9:0] b_vs;
  logic [7:0] b_group, b_src;
  logic [5:0] b_inst;
  logic       b_oready, b_ovalid;
  logic [4:0] b_ovs;
  logic [3:0] b_ogroup, b_osrc;
  logic [2:0] b_oinst;
  logic [0:0] b_ogrant;

  read_stage_rr_arbiter_n #(.N(2), .REG_OUT(0)) u2 (
    .clock(clock), .reset(reset),
    .io_in_valid(b_valid), .io_in_ready(b_ready),
    .io_in_bits_vs(b_vs), .io_in_bits_groupIndex(b_group),
    .io_in_bits_readSource(b_src), .io_in_bits_instructionIndex(b_inst),
    .io_out_ready(b_oready), .io_out_valid(b_ovalid),
    .io_out_bits_vs(b_ovs), .io_out_bits_groupIndex(b_ogroup),
    .io_out_bits_readSource(b_osrc), .io_out_bits_instructionIndex(b_oinst),
    .io_out_bits_grant(b_ogrant)
  );

  typedef struct {
    logic [3:0] valid;
    logic       oready;
    logic [3:0] exp_ready;   // sampled before the edge
    logic       exp_ovalid;  // N=4: after the edge, N=2: before the edge
    logic [1:0] exp_grant;
    logic [4:0] exp_vs;
  } vec_t;

  vec_t tab4[18];
  vec_t tab2[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester data for N=4: vs 8+i, group 15-i, src 3*i, inst i+1.
  task automatic set_a_data();
    for (int i = 0; i < 4; i++) begin
      a_vs[i*5 +: 5]    = 5'(8 + i);
      a_group[i*4 +: 4] = 4'(15 - i);
      a_src[i*4 +: 4]   = 4'(3 * i);
      a_inst[i*3 +: 3]  = 3'(i + 1);
    end
  endtask

  task automatic fill_tables();
    //            valid   ordy  ready   ovalid grant vs
    tab4[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd8};
    tab4[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd9};
    tab4[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 5'd10};
    tab4[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 5'd11};
    tab4[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd8};
    tab4[5]  = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 5'd8};
    tab4[6]  = '{4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd9};
    tab4[7]  = '{4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 5'd11};
    tab4[8]  = '{4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd9};
    tab4[9]  = '{4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 5'd11};
    tab4[10] = '{4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd9};
    tab4[11] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 5'd9};
    tab4[12] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 5'd9};
    tab4[13] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 5'd9};
    tab4[14] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 5'd10};
    tab4[15] = '{4'h0, 1'b0, 4'b0000, 1'b1, 2'd2, 5'd10};
    tab4[16] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd2, 5'd10};
    tab4[17] = '{4'hF, 1'b0, 4'b1000, 1'b1, 2'd3, 5'd11};
    // N=2 combinational: everything checked before the edge; vs0=03, vs1=1C.
    tab2[0]  = '{4'h3, 1'b1, 4'b0001, 1'b1, 2'd0, 5'h03};
    tab2[1]  = '{4'h3, 1'b1, 4'b0010, 1'b1, 2'd1, 5'h1C};
    tab2[2]  = '{4'h3, 1'b1, 4'b0001, 1'b1, 2'd0, 5'h03};
    tab2[3]  = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 5'h00};
    tab2[4]  = '{4'h3, 1'b0, 4'b0000, 1'b1, 2'd1, 5'h1C};
    tab2[5]  = '{4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 5'h1C};
    tab2[6]  = '{4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 5'h1C};
    tab2[7]  = '{4'h1, 1'b1, 4'b0001, 1'b1, 2'd0, 5'h03};
  endtask

  initial begin
    fill_tables();
    set_a_data();
    a_valid  = 4'hF;
    a_oready = 1'b1;
    b_valid  = 2'b11;
    b_oready = 1'b1;
    b_vs     = {5'h1C, 5'h03};
    b_group  = {4'h9, 4'h2};
    b_src    = {4'h5, 4'hA};
    b_inst   = {3'd6, 3'd1};

    // Reset state, with requests already presented.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ovalid", 32'(a_ovalid), 32'd0);
    chk("rst_ready",  32'(a_ready),  32'd0);
    chk("rst_grant",  32'(a_ogrant), 32'd0);
    chk("rst_vs",     32'(a_ovs),    32'd0);
    chk("rst_group",  32'(a_ogroup), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    @(negedge clock);
    b_valid = 2'b00;
    reset   = 1'b0;

    // Table for the registered N=4 instance.
    for (int v = 0; v < 18; v++) begin
      if (v > 0) @(negedge clock);
      a_valid  = tab4[v].valid;
      a_oready = tab4[v].oready;
      #1;
      chk($sformatf("t4[%0d]_ready", v), 32'(a_ready), 32'(tab4[v].exp_ready));
      @(posedge clock);
      #1;
      chk($sformatf("t4[%0d]_ovalid", v), 32'(a_ovalid), 32'(tab4[v].exp_ovalid));
      chk($sformatf("t4[%0d]_grant", v),  32'(a_ogrant), 32'(tab4[v].exp_grant));
      chk($sformatf("t4[%0d]_vs", v),     32'(a_ovs),    32'(tab4[v].exp_vs));
    end
    // Other fields of the last winner (requester 3).
    chk("t4_last_group", 32'(a_ogroup), 32'd12);
    chk("t4_last_src",   32'(a_osrc),   32'd9);
    chk("t4_last_inst",  32'(a_oinst),  32'd4);

    // Only requester 2 valid with distinctive data: it wins every cycle.
    @(negedge clock);
    a_vs[10 +: 5]   = 5'h1B;
    a_group[8 +: 4] = 4'h7;
    a_valid  = 4'b0100;
    a_oready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      chk($sformatf("solo[%0d]_ready", c), 32'(a_ready), 32'h4);
      @(posedge clock);
      #1;
      chk($sformatf("solo[%0d]_ovalid", c), 32'(a_ovalid), 32'd1);
      chk($sformatf("solo[%0d]_vs", c),     32'(a_ovs),    32'h1B);
      chk($sformatf("solo[%0d]_group", c),  32'(a_ogroup), 32'h7);
      chk($sformatf("solo[%0d]_grant", c),  32'(a_ogrant), 32'd2);
    end

    // Asynchronous reset between edges while streaming.
    @(negedge clock);
    set_a_data();
    a_valid = 4'hF;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("areset_ovalid", 32'(a_ovalid), 32'd0);
    chk("areset_ready",  32'(a_ready),  32'd0);
    chk("areset_vs",     32'(a_ovs),    32'd0);
    chk("areset_grant",  32'(a_ogrant), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(a_ready), 32'h1);
    @(posedge clock);
    #1;
    chk("post_rst_grant",  32'(a_ogrant), 32'd0);
    chk("post_rst_ovalid", 32'(a_ovalid), 32'd1);
    chk("post_rst_vs",     32'(a_ovs),    32'd8);

    // Table for the combinational N=2 instance; N=4 instance idles.
    @(negedge clock);
    a_valid = 4'h0;
    for (int v = 0; v < 8; v++) begin
      if (v > 0) @(negedge clock);
      b_valid  = tab2[v].valid[1:0];
      b_oready = tab2[v].oready;
      #1;
      chk($sformatf("t2[%0d]_ready", v),  32'(b_ready),  32'(tab2[v].exp_ready));
      chk($sformatf("t2[%0d]_ovalid", v), 32'(b_ovalid), 32'(tab2[v].exp_ovalid));
      chk($sformatf("t2[%0d]_grant", v),  32'(b_ogrant), 32'(tab2[v].exp_grant));
      chk($sformatf("t2[%0d]_vs", v),     32'(b_ovs),    32'(tab2[v].exp_vs));
      @(posedge clock);
    end
    // All fields zero with nothing valid.
    @(negedge clock);
    b_valid = 2'b00;
    #1;
    chk("t2_idle_group", 32'(b_ogroup), 32'd0);
    chk("t2_idle_src",   32'(b_osrc),   32'd0);
    chk("t2_idle_inst",  32'(b_oinst),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
